// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared constants and helpers for the parametrised serial
//                sequence detector: overlap-mode encodings, default
//                pattern/mask, and the fill-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    // Overlap mode encodings
    localparam logic OVL_OFF = 1'b0;
    localparam logic OVL_ON  = 1'b1;

    // Pattern used by the original fixed-pattern detector, and its mask
    localparam logic [3:0] c_def_pat  = 4'b1101;
    localparam logic [3:0] c_def_mask = 4'b1111;

    // Width needed to count 0..pat_w inclusive
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : W-bit up counter that saturates at all ones. The sat flag is
//                registered alongside the count so it is high exactly while
//                count sits at its maximum.
//  Ports       : clk   - system clock (rising edge)
//                rst   - synchronous active-high reset
//                inc   - increment request for this cycle
//                count - current count
//                sat   - high while count == all ones
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] r_count;
    logic         r_sat;
    logic [W-1:0] w_count_n;

    // r_sat mirrors (r_count == '1), so it doubles as the hold condition
    always_comb begin
        w_count_n = r_count;
        if (inc && !r_sat) begin
            w_count_n = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_count <= w_count_n;
            r_sat   <= (w_count_n == {W{1'b1}});
        end
    end

    assign count = r_count;
    assign sat   = r_sat;

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param
//  Description : Serial sequence detector with a runtime-loadable PAT_W-bit
//                pattern and per-bit don't-care mask. Supports overlapping
//                and non-overlapping detection and a saturating match count.
//  Ports       : clk         - system clock (rising edge)
//                rst         - synchronous active-high reset
//                i           - serial data bit
//                in_valid    - qualifies i
//                pat_load    - load pat_in/mask_in (discards any bit this cycle)
//                pat_in      - new pattern, MSB is the first bit received
//                mask_in     - 1 = compare bit, 0 = don't care
//                overlap     - 1 = overlapping detection, 0 = non-overlapping
//                out         - registered one-cycle match pulse
//                match_count - saturating match count
//                cnt_sat     - high while match_count is all ones
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(c_def_pat)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i,
    input  logic             in_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [PAT_W-1:0] mask_in,
    input  logic             overlap,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat
);

    localparam int             FW          = fill_width(PAT_W);
    localparam logic [FW-1:0]  c_fill_full = FW'(PAT_W);

    logic [PAT_W-1:0] r_hist;
    logic [FW-1:0]    r_fill;
    logic [PAT_W-1:0] r_pat;
    logic [PAT_W-1:0] r_mask;
    logic             r_out;

    logic [PAT_W-1:0] w_hist_n;
    logic [FW-1:0]    w_fill_n;
    logic             w_hit;

    // Candidate history/fill if the current bit is accepted
    always_comb begin
        w_hist_n = {r_hist[PAT_W-2:0], i};
        w_fill_n = (r_fill == c_fill_full) ? r_fill : r_fill + 1'b1;
        w_hit    = in_valid && !pat_load && (w_fill_n == c_fill_full) &&
                   (((w_hist_n ^ r_pat) & r_mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= DEFAULT_PAT;
            r_mask <= '1;
            r_out  <= 1'b0;
        end else if (pat_load) begin
            r_pat  <= pat_in;
            r_mask <= mask_in;
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else if (in_valid) begin
            r_out <= w_hit;
            if (w_hit && (overlap == OVL_OFF)) begin
                // Non-overlapping: the next match needs PAT_W fresh bits
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                // On an overlapping hit w_fill_n is already PAT_W
                r_hist <= w_hist_n;
                r_fill <= w_fill_n;
            end
        end else begin
            r_out <= 1'b0;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_hit),
        .count (match_count),
        .sat   (cnt_sat)
    );

    assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detector_param
//  Description : Directed self-checking bench for seq_detector_param. A second
//                instance with CNT_W=2 and an all-ones default pattern covers
//                counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // Main instance stimulus
    logic       i = 1'b0, in_valid = 1'b0, pat_load = 1'b0, overlap = 1'b1;
    logic [3:0] pat_in = 4'b0000, mask_in = 4'b0000;
    logic       out;
    logic [7:0] match_count;
    logic       cnt_sat;

    // Saturation instance stimulus
    logic       i2 = 1'b0, v2 = 1'b0, load2 = 1'b0, ovl2 = 1'b1;
    logic [3:0] pat2 = 4'b0000, mask2 = 4'b0000;
    logic       out2;
    logic [1:0] cnt2;
    logic       sat2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in), .mask_in(mask_in), .overlap(overlap),
        .out(out), .match_count(match_count), .cnt_sat(cnt_sat)
    );

    seq_detector_param #(.PAT_W(4), .CNT_W(2), .DEFAULT_PAT(4'b1111)) dut2 (
        .clk(clk), .rst(rst), .i(i2), .in_valid(v2), .pat_load(load2),
        .pat_in(pat2), .mask_in(mask2), .overlap(ovl2),
        .out(out2), .match_count(cnt2), .cnt_sat(sat2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge
    task automatic send(input logic b);
        @(negedge clk);
        i = b; in_valid = 1'b1; pat_load = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; pat_load = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; pat_load = 1'b0; v2 = 1'b0; load2 = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Send nbits from the MSB of bits, checking out against exp each bit
    task automatic run_stream(input string tag, input logic [15:0] bits,
                              input logic [15:0] exp, input int nbits);
        for (int k = nbits - 1; k >= 0; k--) begin
            send(bits[k]);
            chk($sformatf("%s_out_b%0d", tag, nbits - k), {31'd0, out}, {31'd0, exp[k]});
        end
    endtask

    initial begin
        // ---- 1: reset state, then overlapping detection of 1101101
        do_reset();
        chk("rst_out", {31'd0, out}, 32'd0);
        chk("rst_cnt", {24'd0, match_count}, 32'd0);
        chk("rst_sat", {31'd0, cnt_sat}, 32'd0);
        overlap = 1'b1;
        run_stream("t1", 16'b1101101, 16'b0001001, 7);
        chk("t1_cnt", {24'd0, match_count}, 32'd2);

        // ---- 2: same stream, non-overlapping
        do_reset();
        overlap = 1'b0;
        run_stream("t2", 16'b1101101, 16'b0001000, 7);
        chk("t2_cnt", {24'd0, match_count}, 32'd1);

        // ---- 3: load 1001 with bit 2 don't care; 1101 then 1001
        do_reset();
        @(negedge clk);
        pat_load = 1'b1; pat_in = 4'b1001; mask_in = 4'b1011; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t3_load_cnt", {24'd0, match_count}, 32'd0);
        overlap = 1'b0;
        run_stream("t3", 16'b11011001, 16'b00010001, 8);
        chk("t3_cnt", {24'd0, match_count}, 32'd2);

        // ---- 4: gaps in the valid strobe do not disturb fill
        do_reset();
        overlap = 1'b1;
        run_stream("t4a", 16'b11, 16'b00, 2);
        for (int g = 0; g < 3; g++) begin
            idle();
            chk($sformatf("t4_gap%0d", g), {31'd0, out}, 32'd0);
        end
        run_stream("t4b", 16'b01, 16'b01, 2);
        idle();
        chk("t4_pulse_end", {31'd0, out}, 32'd0);
        chk("t4_cnt", {24'd0, match_count}, 32'd1);

        // ---- 5: CNT_W=2 instance, nine 1s, overlapping on pattern 1111
        do_reset();
        chk("t5_rst_cnt", {30'd0, cnt2}, 32'd0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            i2 = 1'b1; v2 = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("t5_out_b%0d", k), {31'd0, out2}, (k >= 4) ? 32'd1 : 32'd0);
            chk($sformatf("t5_cnt_b%0d", k), {30'd0, cnt2},
                (k < 4) ? 32'd0 : ((k - 3 > 3) ? 32'd3 : 32'(k - 3)));
            chk($sformatf("t5_sat_b%0d", k), {31'd0, sat2}, (k >= 6) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        v2 = 1'b0;

        // ---- 6: reset mid-pattern, then load with a coincident valid bit
        do_reset();
        overlap = 1'b1;
        run_stream("t6a", 16'b110, 16'b000, 3);
        do_reset();
        run_stream("t6b", 16'b1, 16'b0, 1);
        chk("t6_cnt_after_rst", {24'd0, match_count}, 32'd0);
        @(negedge clk);
        pat_load = 1'b1; pat_in = 4'b1101; mask_in = 4'b1111; in_valid = 1'b1; i = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_load_out", {31'd0, out}, 32'd0);
        // If the load-cycle bit had been kept, 101 would complete 1101 here
        run_stream("t6c", 16'b101, 16'b000, 3);
        run_stream("t6d", 16'b1101, 16'b0001, 4);
        chk("t6_cnt", {24'd0, match_count}, 32'd1);

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
